// File: rtl/fx3_slave_write.sv
// Drains the prefetch FIFO head into the FX3 GPIF II synchronous slave FIFO.
// Full DMA buffers auto-commit; partial buffers are committed with PKTEND#.
module fx3_slave_write #(
    parameter int unsigned BURST_WORDS    = 4096,
    parameter int unsigned FLAG_LAT       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [1:0]  SOCKET_ADDR    = 2'b00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_top_i,
    input  logic        data_valid_second_i,
    input  logic        data_valid_third_i,
    output logic        data_read_o,
    input  logic        fx3_flaga_i,
    output logic [31:0] fx3_dq_o,
    output logic        fx3_slwr_n_o,
    output logic        fx3_slcs_n_o,
    output logic        fx3_sloe_n_o,
    output logic        fx3_slrd_n_o,
    output logic        fx3_pktend_n_o,
    output logic [1:0]  fx3_addr_o,
    output logic [31:0] buffer_count_o,
    output logic [31:0] word_count_o
);

    localparam int unsigned FILL_W = $clog2(BURST_WORDS + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GRD_W  = $clog2(FLAG_LAT + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BURST_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(FLAG_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FLAG,
        S_WRITE,
        S_PKTEND,
        S_GUARD
    } state_t;

    state_t            state_q;
    logic              flaga_s_q;
    logic [FILL_W-1:0] fill_q;
    logic [TMR_W-1:0]  timer_q;
    logic [GRD_W-1:0]  guard_q;
    logic [31:0]       dq_q;
    logic              slwr_n_q;
    logic              slcs_n_q;
    logic              pktend_n_q;
    logic [31:0]       buffer_count_q;
    logic [31:0]       word_count_q;

    logic pop;
    logic any_valid;

    assign pop       = (state_q == S_WRITE) && data_valid_top_i && enable_i;
    assign any_valid = data_valid_top_i || data_valid_second_i || data_valid_third_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            flaga_s_q      <= 1'b0;
            fill_q         <= '0;
            timer_q        <= '0;
            guard_q        <= '0;
            dq_q           <= '0;
            slwr_n_q       <= 1'b1;
            slcs_n_q       <= 1'b1;
            pktend_n_q     <= 1'b1;
            buffer_count_q <= '0;
            word_count_q   <= '0;
        end else begin
            flaga_s_q  <= fx3_flaga_i;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    slcs_n_q <= 1'b1;
                    if (enable_i) begin
                        state_q  <= S_WAIT_FLAG;
                        slcs_n_q <= 1'b0;
                    end
                end
                S_WAIT_FLAG: begin
                    if (!enable_i) begin
                        state_q  <= S_IDLE;
                        slcs_n_q <= 1'b1;
                    end else if (flaga_s_q) begin
                        state_q <= S_WRITE;
                        timer_q <= '0;
                    end
                end
                S_WRITE: begin
                    if (!enable_i) begin
                        if (fill_q != '0) begin
                            state_q        <= S_PKTEND;
                            pktend_n_q     <= 1'b0;
                            buffer_count_q <= buffer_count_q + 1'b1;
                            fill_q         <= '0;
                        end else begin
                            state_q  <= S_IDLE;
                            slcs_n_q <= 1'b1;
                        end
                    end else if (pop) begin
                        dq_q         <= data_i;
                        slwr_n_q     <= 1'b0;
                        word_count_q <= word_count_q + 1'b1;
                        timer_q      <= '0;
                        // Last word of a buffer: FX3 commits it on its own, no PKTEND#.
                        if (fill_q == FILL_LAST) begin
                            fill_q         <= '0;
                            buffer_count_q <= buffer_count_q + 1'b1;
                            state_q        <= S_GUARD;
                            guard_q        <= '0;
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end else if (any_valid) begin
                        timer_q <= '0;
                    end else if (timer_q == TMR_LAST && fill_q != '0) begin
                        state_q        <= S_PKTEND;
                        pktend_n_q     <= 1'b0;
                        buffer_count_q <= buffer_count_q + 1'b1;
                        fill_q         <= '0;
                    end else if (timer_q != TMR_MAX) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_PKTEND: begin
                    state_q <= S_GUARD;
                    guard_q <= '0;
                end
                S_GUARD: begin
                    if (guard_q == GRD_LAST) begin
                        state_q  <= enable_i ? S_WAIT_FLAG : S_IDLE;
                        slcs_n_q <= !enable_i;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    slcs_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign data_read_o    = pop;
    assign fx3_dq_o       = dq_q;
    assign fx3_slwr_n_o   = slwr_n_q;
    assign fx3_slcs_n_o   = slcs_n_q;
    assign fx3_sloe_n_o   = 1'b1;
    assign fx3_slrd_n_o   = 1'b1;
    assign fx3_pktend_n_o = pktend_n_q;
    assign fx3_addr_o     = SOCKET_ADDR;
    assign buffer_count_o = buffer_count_q;
    assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_fx3_slave_write.sv
// Directed/randomized bench for fx3_slave_write with a transaction-level model:
// every pop must appear on DQ one clock later, buffers commit at BURST_WORDS or via PKTEND#.
module tb_fx3_slave_write;

    localparam int          BURST    = 4096;
    localparam int          FLAG_LAT = 3;
    localparam int          TIMEOUT  = 1024;
    localparam logic [1:0]  SOCK     = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] data = '0;
    logic        dv_top = 1'b0;
    logic        dv2 = 1'b0;
    logic        dv3 = 1'b0;
    logic        data_read;
    logic        flaga = 1'b0;
    logic [31:0] dq;
    logic        slwr_n, slcs_n, sloe_n, slrd_n, pktend_n;
    logic [1:0]  addr;
    logic [31:0] buffer_count, word_count;

    fx3_slave_write #(
        .BURST_WORDS    (BURST),
        .FLAG_LAT       (FLAG_LAT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SOCKET_ADDR    (SOCK)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .enable_i            (enable),
        .data_i              (data),
        .data_valid_top_i    (dv_top),
        .data_valid_second_i (dv2),
        .data_valid_third_i  (dv3),
        .data_read_o         (data_read),
        .fx3_flaga_i         (flaga),
        .fx3_dq_o            (dq),
        .fx3_slwr_n_o        (slwr_n),
        .fx3_slcs_n_o        (slcs_n),
        .fx3_sloe_n_o        (sloe_n),
        .fx3_slrd_n_o        (slrd_n),
        .fx3_pktend_n_o      (pktend_n),
        .fx3_addr_o          (addr),
        .buffer_count_o      (buffer_count),
        .word_count_o        (word_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_word = '0;
    int unsigned exp_words = 0;
    int unsigned exp_bufs = 0;
    int          fill_m = 0;
    int          pkt_count = 0;
    int          last_commit = -100;
    int          last_pop_cyc = 0;
    int          pktend_cyc = 0;
    bit          prev_pkt = 1'b0;
    bit          use_seq = 1'b0;
    logic [31:0] src_seq = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the pop decision before the edge, check its effect after it.
    task automatic tick();
        bit popped;
        popped = 1'b0;
        #1;
        if (data_read === 1'b1) begin
            chk("pop_gate", 32'(enable && dv_top), 32'd1);
            chk("guard_gap", 32'((cyc - last_commit) >= FLAG_LAT + 1), 32'd1);
            pend      = 1'b1;
            pend_word = data;
            exp_words++;
            fill_m++;
            last_pop_cyc = cyc;
            popped = 1'b1;
            if (fill_m == BURST) begin
                exp_bufs++;
                fill_m = 0;
                last_commit = cyc;
            end
        end
        @(negedge clk);
        cyc++;
        if (pend) begin
            chk("slwr_after_pop", 32'(slwr_n), 32'd0);
            chk("dq_order", dq, pend_word);
        end else begin
            chk("slwr_idle", 32'(slwr_n), 32'd1);
        end
        pend = 1'b0;
        if (pktend_n === 1'b0) begin
            pkt_count++;
            pktend_cyc = cyc;
            chk("pkt_single", 32'(prev_pkt), 32'd0);
            chk("pkt_nonempty", 32'(fill_m != 0), 32'd1);
            exp_bufs++;
            fill_m = 0;
            last_commit = cyc;
        end
        prev_pkt = (pktend_n === 1'b0);
        chk("word_count", word_count, exp_words);
        chk("buffer_count", buffer_count, exp_bufs);
        chk("static_pins", 32'({sloe_n, slrd_n, addr}), 32'({2'b11, SOCK}));
        if (popped) begin
            src_seq = src_seq + 1;
            data = use_seq ? src_seq : $urandom;
        end
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_strobes", 32'({slwr_n, pktend_n, slcs_n, sloe_n, slrd_n}), 32'h1f);
        chk("rst_dq", dq, 32'd0);
        chk("rst_addr", 32'(addr), 32'(SOCK));
        chk("rst_read", 32'(data_read), 32'd0);
        chk("rst_counts", buffer_count | word_count, 32'd0);
        pend = 1'b0; exp_words = 0; exp_bufs = 0; fill_m = 0;
        pkt_count = 0; prev_pkt = 1'b0; last_commit = -100;
        enable = 1'b0; dv_top = 1'b0; dv2 = 1'b0; dv3 = 1'b0; flaga = 1'b0;
        src_seq = '0;
        data = use_seq ? '0 : $urandom;
        @(negedge clk);
        #1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int pulse_cyc;

        // Reset state and idle with enable low
        apply_reset();
        repeat (2) tick();
        chk("idle_slcs", 32'(slcs_n), 32'd1);

        // Flag wait: no writes until FLAGA, then three clocks to the first SLWR#
        apply_reset();
        use_seq = 1'b0;
        enable = 1'b1; dv_top = 1'b1; flaga = 1'b0;
        repeat (20) tick();
        chk("t3_no_write", exp_words, 32'd0);
        chk("t3_slcs", 32'(slcs_n), 32'd0);
        flaga = 1'b1;
        t0 = cyc;
        n = 0;
        while (slwr_n !== 1'b0 && n < 10) begin tick(); n++; end
        chk("t3_latency", 32'(cyc - t0), 32'd3);

        // 5000 sequential words, FLAGA dropping mid-buffer must be ignored
        use_seq = 1'b1;
        apply_reset();
        enable = 1'b1; flaga = 1'b1;
        n = 0;
        while (exp_words < 5000 && n < 8000) begin
            dv_top = 1'b1;
            dv2 = 1'($urandom);
            dv3 = 1'($urandom);
            flaga = !(exp_words >= 1000 && exp_words < 1500);
            tick();
            n++;
        end
        dv_top = 1'b0; dv2 = 1'b0; dv3 = 1'b0; flaga = 1'b1;
        repeat (3) tick();
        chk("t1_words", word_count, 32'd5000);
        chk("t1_bufs", buffer_count, 32'd1);
        chk("t1_no_pktend", 32'(pkt_count), 32'd0);

        // Idle timeout after 10 words, then a lone valid flag restarting the timer
        use_seq = 1'b0;
        apply_reset();
        enable = 1'b1; flaga = 1'b1;
        n = 0;
        while (exp_words < 10 && n < 100) begin dv_top = 1'b1; tick(); n++; end
        dv_top = 1'b0;
        n = 0;
        while (pkt_count == 0 && n < 2000) begin tick(); n++; end
        chk("t2_pkt_delay", 32'(pktend_cyc - last_pop_cyc), 32'(TIMEOUT + 1));
        chk("t2_bufs", buffer_count, 32'd1);
        repeat (1500) tick();
        chk("t2_no_zlp", 32'(pkt_count), 32'd1);
        n = 0;
        while (exp_words < 15 && n < 100) begin dv_top = 1'b1; tick(); n++; end
        dv_top = 1'b0;
        repeat (600) tick();
        dv3 = 1'b1;
        pulse_cyc = cyc;
        tick();
        dv3 = 1'b0;
        n = 0;
        while (pkt_count == 1 && n < 2000) begin tick(); n++; end
        chk("t2_valid_clears_timer", 32'(pktend_cyc - pulse_cyc), 32'(TIMEOUT + 1));
        chk("t2_bufs2", buffer_count, 32'd2);

        // Disable after 100 words with random gaps
        apply_reset();
        enable = 1'b1; flaga = 1'b1;
        n = 0;
        while (exp_words < 100 && n < 1000) begin
            dv_top = ($urandom_range(3) != 0);
            dv2 = 1'($urandom);
            dv3 = 1'($urandom);
            tick();
            n++;
        end
        enable = 1'b0; dv_top = 1'b1;
        repeat (20) tick();
        chk("t4_words", word_count, 32'd100);
        chk("t4_pkt", 32'(pkt_count), 32'd1);
        chk("t4_bufs", buffer_count, 32'd1);
        chk("t4_slcs", 32'(slcs_n), 32'd1);

        // Disable with an empty buffer
        apply_reset();
        enable = 1'b1; flaga = 1'b1; dv_top = 1'b0;
        repeat (6) tick();
        chk("t5_slcs_active", 32'(slcs_n), 32'd0);
        enable = 1'b0;
        tick();
        chk("t5_slcs_idle", 32'(slcs_n), 32'd1);
        repeat (10) tick();
        chk("t5_no_pkt", 32'(pkt_count), 32'd0);
        chk("t5_bufs", buffer_count, 32'd0);

        // Reset at word 2000, then a full buffer boundary from a fresh fill
        apply_reset();
        enable = 1'b1; flaga = 1'b1;
        n = 0;
        while (exp_words < 2000 && n < 4000) begin
            dv_top = ($urandom_range(7) != 0);
            dv2 = 1'($urandom);
            tick();
            n++;
        end
        dv_top = 1'b1;
        apply_reset();
        enable = 1'b1; flaga = 1'b1;
        n = 0;
        while (exp_words < BURST + 50 && n < 10000) begin
            dv_top = ($urandom_range(7) != 0);
            dv3 = 1'($urandom);
            tick();
            n++;
        end
        dv_top = 1'b0; dv3 = 1'b0;
        repeat (3) tick();
        chk("t6_words", word_count, 32'(BURST + 50));
        chk("t6_bufs", buffer_count, 32'd1);
        chk("t6_no_pkt", 32'(pkt_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx3_slave_write.md
Name: fx3_slave_write

Overview:
- Drains the 3-deep prefetch FIFO output (32-bit word, three valid flags, read strobe) and writes it to the Cypress FX3 GPIF II synchronous slave FIFO.
- Drives the FX3 write interface: DQ, SLWR#, SLCS#, SLOE#, SLRD#, PKTEND#, socket address.
- Writes full DMA buffers of BURST_WORDS words and honours the FX3 flag latency.
- Commits short packets with PKTEND# after an idle timeout or on disable.

Parameters:
- BURST_WORDS, 4096: words per FX3 DMA buffer (16 KB); FX3 auto-commits when a buffer fills.
- FLAG_LAT, 3: guard cycles after a buffer commit before FLAGA is trusted.
- TIMEOUT_CYCLES, 1024: idle cycles with a partial buffer before PKTEND# is asserted.
- SOCKET_ADDR, 2'b00: constant value driven on fx3_addr_o.

Ports:
- clk  in  1  FX3 PCLK domain clock (100 MHz); FX3 flags are synchronous to it.
- rstn  in  1  asynchronous active-low reset.
- enable_i  in  1  streaming enable.
- data_i  in  32  head word of the prefetch FIFO.
- data_valid_top_i  in  1  data_i is valid.
- data_valid_second_i  in  1  second prefetch stage holds a word.
- data_valid_third_i  in  1  decoupler FIFO is not empty.
- data_read_o  out  1  pops data_i this cycle (combinational).
- fx3_flaga_i  in  1  1 = current socket buffer has space.
- fx3_dq_o  out  32  write data.
- fx3_slwr_n_o  out  1  write strobe, active low.
- fx3_slcs_n_o  out  1  chip select, active low.
- fx3_sloe_n_o  out  1  output enable; tied high (inactive).
- fx3_slrd_n_o  out  1  read strobe; tied high (inactive).
- fx3_pktend_n_o  out  1  packet end, active low.
- fx3_addr_o  out  2  socket address; always SOCKET_ADDR.
- buffer_count_o  out  32  number of committed buffers, full plus short.
- word_count_o  out  32  total words written.

Behaviour:
- Reset (async, rstn=0), all outputs forced immediately:
  - slwr_n=1, pktend_n=1, slcs_n=1, sloe_n=1, slrd_n=1.
  - dq=0, addr=SOCKET_ADDR, data_read_o=0.
  - Both counters 0; state IDLE; fill and timer counters 0.
- All FX3 outputs are registered. fx3_flaga_i is registered once (flaga_s) before any use.
- States: IDLE, WAIT_FLAG, WRITE, PKTEND, GUARD.
- IDLE:
  - slcs_n=1.
  - enable_i=1 -> WAIT_FLAG, with slcs_n=0 from the next cycle.
- WAIT_FLAG:
  - enable_i=0 -> IDLE.
  - flaga_s=1 -> WRITE.
- WRITE:
  - data_read_o = data_valid_top_i & enable_i.
  - On each pop, at the next edge: dq<=data_i, slwr_n<=0, fill+1, word_count+1, timer<=0.
  - Cycles without a pop: slwr_n<=1.
  - Pop latency: one clock from data_read_o to slwr_n low on the FX3 pins.
- Buffer full:
  - The pop that makes fill==BURST_WORDS leaves WRITE -> GUARD.
  - Same edge: fill<=0, buffer_count+1, no PKTEND#.
  - At most BURST_WORDS slwr pulses per buffer, never more.
- Idle timeout:
  - In WRITE, the timer increments only when data_valid_top_i, data_valid_second_i and data_valid_third_i are all 0.
  - The timer is cleared by any pop or by any valid flag going high.
  - timer==TIMEOUT_CYCLES-1 with fill>0 -> PKTEND.
  - With fill==0 the timer saturates; no PKTEND# and no zero-length packet is ever sent.
- enable_i=0 in WRITE:
  - No pop that cycle.
  - fill>0 -> PKTEND; fill==0 -> IDLE.
- PKTEND:
  - Exactly one cycle with pktend_n=0 and slwr_n=1 (standalone short-packet commit).
  - Same edge: buffer_count+1, fill<=0.
  - Then GUARD.
- GUARD:
  - FLAG_LAT cycles with slwr_n=1 and data_read_o=0.
  - Then WAIT_FLAG if enable_i=1, else IDLE.
- Flag priority:
  - FLAGA is sampled only in WAIT_FLAG.
  - flaga_s falling during WRITE is ignored; buffer capacity is guaranteed by the fill counter.
- Simultaneous events (both in WRITE):
  - Pop and timeout expiry in the same cycle: the pop wins and the timer clears.
  - Pop reaching BURST_WORDS while enable_i falls: not possible, because the pop is gated by enable_i.
- Counters wrap modulo 2^32.
- fill width is clog2(BURST_WORDS+1); timer width is clog2(TIMEOUT_CYCLES+1).
- Reset mid-burst:
  - All outputs return to their reset values immediately; no PKTEND# is issued.
  - The partial FX3 buffer is discarded by firmware.

Test Plan:
1. enable_i=1, flaga=1, 5000 words continuously valid:
   - First 4096 slwr_n pulses carry words 0..4095 in order.
   - Then 3 guard cycles plus the flag wait with slwr_n=1.
   - Words 4096..4999 follow.
   - buffer_count_o=1, word_count_o=5000, pktend_n never low.
2. 10 words, then all valids 0 for 1024+ cycles:
   - Exactly one pktend_n=0 cycle with slwr_n=1, 1024 cycles after the last pop's timer start.
   - buffer_count_o=1; GUARD then WAIT_FLAG follow.
3. fx3_flaga_i=0 at enable:
   - State held in WAIT_FLAG, data_read_o=0, no slwr.
   - flaga set to 1 -> first slwr_n low 3 cycles later: flag register, WRITE, pop register.
4. enable_i dropped after 100 words:
   - No further pops; one pktend_n pulse; buffer_count_o=1; slcs_n=1 back in IDLE.
5. enable_i dropped with fill=0:
   - No pktend_n pulse; direct transition to IDLE.
6. rstn asserted low mid-burst at word 2000:
   - Outputs immediately at reset values, counters 0.
   - After release and enable, fill restarts at 0 and the full 4096-word boundary is honoured.
